// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path: RAMqueue geometry
// and the capture FSM state encoding.
package la_pkg;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/smpl_dec.sv
// Sample-rate decimator: produces a one-cycle sample strobe every
// 2^decimator clocks while enabled, and holds its counter at zero otherwise.
module smpl_dec (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] decimator,
  output logic       smpl_en
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] period_m1_s;

  assign period_m1_s = (16'd1 << decimator) - 16'd1;
  assign smpl_en     = en && (cnt_q == period_m1_s);

  // Next count: cleared outside RUN so every capture starts phase-aligned
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = 16'd0;
    end else if (smpl_en) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: runs the RAMqueue write pointer as a circular buffer,
// arms once enough pre-trigger history is stored, and stops tp samples after
// the accepted trigger, leaving the oldest-sample address for the dump.
module capture_ctrl
  import la_pkg::*;
#(
  parameter int ENTRIES = la_pkg::ENTRIES,
  parameter int LOG2    = la_pkg::LOG2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_en,
  input  logic            capture_done,
  input  logic            trig,
  input  logic [3:0]      decimator,
  input  logic [LOG2-1:0] trig_pos,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic [LOG2-1:0] ram_addr,
  output logic            set_capture_done,
  output logic            armed,
  output logic            capturing
);

  localparam logic [LOG2-1:0] LAST_A = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   FULL_C = (LOG2 + 1)'(ENTRIES);

  cap_state_t      state_q, state_d;
  logic [LOG2-1:0] wptr_q, wptr_d;
  logic [LOG2:0]   cnt_q, cnt_d;
  logic [LOG2-1:0] ptcnt_q, ptcnt_d;
  logic            trig_q, trig_d;
  logic            armed_q, armed_d;
  logic [LOG2-1:0] ram_addr_q, ram_addr_d;
  logic            set_done_q, set_done_d;

  logic            smpl_en_s;
  logic            in_run_s;
  logic [LOG2-1:0] tp_s;
  logic [LOG2:0]   arm_thr_s;
  logic [LOG2-1:0] wptr_nxt_s;
  logic [LOG2:0]   cnt_nxt_s;
  logic            accept_s;
  logic            term_s;

  assign in_run_s = (state_q == RUN);

  smpl_dec u_smpl_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (in_run_s),
    .decimator (decimator),
    .smpl_en   (smpl_en_s)
  );

  assign tp_s       = (trig_pos > LAST_A) ? LAST_A : trig_pos;
  assign arm_thr_s  = FULL_C - {1'b0, tp_s};
  assign wptr_nxt_s = !we ? wptr_q : ((wptr_q == LAST_A) ? {LOG2{1'b0}} : wptr_q + 1'b1);
  assign cnt_nxt_s  = (we && (cnt_q < FULL_C)) ? cnt_q + 1'b1 : cnt_q;
  // A write on the accepting cycle is still pre-trigger: trig_q is not yet set
  assign accept_s   = trig && armed_q && !trig_q;
  assign term_s     = in_run_s &&
                      ((trig_q && we && ((ptcnt_q + 1'b1) == tp_s)) ||
                       (accept_s && (tp_s == {LOG2{1'b0}})));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (run_en && !capture_done) state_d = RUN;
        else                         state_d = IDLE;
      end
      RUN: begin
        if (term_s) state_d = DONE;
        else        state_d = RUN;
      end
      DONE: begin
        if (!capture_done) state_d = IDLE;
        else               state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    we        = 1'b0;
    capturing = 1'b0;
    case (state_q)
      RUN: begin
        we        = smpl_en_s;
        capturing = 1'b1;
      end
      IDLE, DONE: begin
        we        = 1'b0;
        capturing = 1'b0;
      end
      default: begin
        we        = 1'b0;
        capturing = 1'b0;
      end
    endcase
  end

  // Pointer, counters and flags; IDLE keeps them cleared for the next run
  always_comb begin
    wptr_d     = wptr_q;
    cnt_d      = cnt_q;
    ptcnt_d    = ptcnt_q;
    trig_d     = trig_q;
    armed_d    = armed_q;
    ram_addr_d = ram_addr_q;
    set_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        wptr_d  = {LOG2{1'b0}};
        cnt_d   = {(LOG2 + 1){1'b0}};
        ptcnt_d = {LOG2{1'b0}};
        trig_d  = 1'b0;
        armed_d = 1'b0;
      end
      RUN: begin
        wptr_d  = wptr_nxt_s;
        cnt_d   = cnt_nxt_s;
        ptcnt_d = (trig_q && we) ? ptcnt_q + 1'b1 : ptcnt_q;
        trig_d  = trig_q | accept_s;
        if (term_s) begin
          armed_d    = 1'b0;
          set_done_d = 1'b1;
          ram_addr_d = wptr_nxt_s;
        end else begin
          armed_d = armed_q | (cnt_nxt_s >= arm_thr_s);
        end
      end
      DONE: begin
        armed_d = 1'b0;
      end
      default: begin
        wptr_d  = {LOG2{1'b0}};
        cnt_d   = {(LOG2 + 1){1'b0}};
        ptcnt_d = {LOG2{1'b0}};
        trig_d  = 1'b0;
        armed_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= {LOG2{1'b0}};
      cnt_q      <= {(LOG2 + 1){1'b0}};
      ptcnt_q    <= {LOG2{1'b0}};
      trig_q     <= 1'b0;
      armed_q    <= 1'b0;
      ram_addr_q <= {LOG2{1'b0}};
      set_done_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
      ptcnt_q    <= ptcnt_d;
      trig_q     <= trig_d;
      armed_q    <= armed_d;
      ram_addr_q <= ram_addr_d;
      set_done_q <= set_done_d;
    end
  end

  assign waddr            = wptr_q;
  assign ram_addr         = ram_addr_q;
  assign armed            = armed_q;
  assign set_capture_done = set_done_q;

endmodule
